// File: rtl/fuel_tank.sv
// Rally-game fuel reservoir: periodic burn, refuel pickups, low-fuel lamp and sticky time-out.
// Optional build macro FUEL_BLINK_EN makes low_fuel blink with half-period BLINK_TICKS.
module fuel_tank #(
    parameter int unsigned FUEL_MAX       = 96,
    parameter int unsigned LVL_W          = 7,
    parameter int unsigned TICKS_PER_UNIT = 12500000,
    parameter int unsigned CNT_W          = 24,
    parameter int unsigned REFILL_AMT     = 24,
    parameter int unsigned LOW_THRESH     = 16,
    parameter int unsigned BLINK_TICKS    = 12500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             boost,
    input  logic             refuel,
    output logic [LVL_W-1:0] fuel_level,
    output logic             low_fuel,
    output logic             empty_pulse,
    output logic             time_out
);

    localparam int unsigned      SUM_W     = LVL_W + 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS_PER_UNIT - 1);

    // Elaboration-time guard against parameter sets the counters or level cannot hold.
    if ((FUEL_MAX + REFILL_AMT) >> LVL_W != 0 || TICKS_PER_UNIT == 0 || BLINK_TICKS == 0
        || (TICKS_PER_UNIT - 1) >> CNT_W != 0 || (BLINK_TICKS - 1) >> CNT_W != 0) begin : g_bad_cfg
        $error("fuel_tank: parameter set does not fit LVL_W/CNT_W");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURN  = 2'd1,
        EMPTY = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] tick_cnt;

    logic             burn_c;
    logic [1:0]       dec_c;
    logic [LVL_W-1:0] t_c;
    logic [SUM_W-1:0] sum_c;
    logic [LVL_W-1:0] next_lvl_c;
    logic             low_cond_c;

    // Next fuel level: burn (clamped at 0), then refuel, then saturate at FUEL_MAX.
    always_comb begin
        burn_c = (state == BURN) && !pause && (tick_cnt == TICK_LAST);
        dec_c  = 2'd0;
        if (burn_c) begin
            dec_c = boost ? 2'd2 : 2'd1;
        end
        t_c   = (fuel_level > LVL_W'(dec_c)) ? (fuel_level - LVL_W'(dec_c)) : '0;
        sum_c = SUM_W'(t_c);
        if (refuel && (state != EMPTY)) begin
            sum_c = sum_c + SUM_W'(REFILL_AMT);
        end
        next_lvl_c = (sum_c > SUM_W'(FUEL_MAX)) ? LVL_W'(FUEL_MAX) : LVL_W'(sum_c);
        low_cond_c = (next_lvl_c != '0) && (next_lvl_c <= LVL_W'(LOW_THRESH));
    end

    // Control FSM, burn-period counter, level register and empty flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            fuel_level  <= LVL_W'(FUEL_MAX);
            empty_pulse <= 1'b0;
            time_out    <= 1'b0;
        end else begin
            empty_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    fuel_level <= next_lvl_c;
                    if (start) begin
                        state <= BURN;
                    end
                end
                BURN: begin
                    if (!pause) begin
                        tick_cnt <= burn_c ? '0 : tick_cnt + CNT_W'(1);
                    end
                    fuel_level <= next_lvl_c;
                    if (next_lvl_c == '0) begin
                        state       <= EMPTY;
                        time_out    <= 1'b1;
                        empty_pulse <= 1'b1;
                    end
                end
                default: begin
                    // EMPTY holds everything until reset
                end
            endcase
        end
    end

`ifdef FUEL_BLINK_EN
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_TICKS - 1);

    logic [CNT_W-1:0] blink_cnt;
    logic             low_act;

    // Blink the lamp while the low condition holds, always starting lit; free-runs through pause.
    always_ff @(posedge clk) begin
        if (rst || !low_cond_c) begin
            blink_cnt <= '0;
            low_act   <= 1'b0;
            low_fuel  <= 1'b0;
        end else if (!low_act) begin
            blink_cnt <= '0;
            low_act   <= 1'b1;
            low_fuel  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            low_fuel  <= ~low_fuel;
        end else begin
            blink_cnt <= blink_cnt + CNT_W'(1);
        end
    end
`else
    // Steady lamp; EMPTY forces next level 0, so the lamp is dark there.
    always_ff @(posedge clk) begin
        if (rst) begin
            low_fuel <= 1'b0;
        end else begin
            low_fuel <= low_cond_c;
        end
    end
`endif

endmodule
